riscv_mdu_seq: RTL and testbench
================================

RISCV_MDU_SEQ -- requirements
Module: riscv_mdu_seq

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand/result width (even, >=8).
REQ-002 SHALL have parameter TAGW, default 5, width of pass-through destination tag.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port flush  input  1  synchronous abort of any operation in flight.
REQ-006 SHALL have port in_valid  input  1  request present.
REQ-007 SHALL have port in_ready  output  1  unit can accept request.
REQ-008 SHALL have port instruction  input  32  RV32 instruction word; funct3/funct7/opcode decoded here.
REQ-009 SHALL have port rs1  input  XLEN  first operand.
REQ-010 SHALL have port rs2  input  XLEN  second operand.
REQ-011 SHALL have port in_tag  input  TAGW  destination tag.
REQ-012 SHALL have port out_valid  output  1  result present.
REQ-013 SHALL have port out_ready  input  1  consumer takes result.
REQ-014 SHALL have port result  output  XLEN  operation result.
REQ-015 SHALL have port out_tag  output  TAGW  tag captured at acceptance.
REQ-016 SHALL have port out_illegal  output  1  accepted instruction not an M-extension op.

Function
REQ-017 SHALL implement states IDLE, CALC, FIX, DONE; in_ready = (state==IDLE).
REQ-018 SHALL accept on rising edge with in_valid & in_ready & ~flush, capturing rs1, rs2, in_tag, funct3.
REQ-019 SHALL treat as legal only opcode[6:0]=0110011 with funct7=0000001; funct3 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-020 Illegal accept SHALL go IDLE->DONE with result=0, out_illegal=1.
REQ-021 Divide with rs2=0 SHALL go IDLE->DONE: DIV/DIVU quotient all-ones, REM/REMU remainder = rs1.
REQ-022 DIV/REM with rs1=-2^(XLEN-1), rs2=-1 SHALL go IDLE->DONE: DIV result=rs1, REM result=0.
REQ-023 All other legal ops SHALL go IDLE->CALC, converting signed operands to magnitudes per op signedness and recording result sign.
REQ-024 CALC SHALL perform one radix-2 iteration per cycle (shift-add multiply, restoring divide) using a counter of width clog2(XLEN)+1, exactly XLEN cycles, then ->FIX.
REQ-025 FIX SHALL apply sign correction (2XLEN-bit product negate; quotient sign = sign(rs1)^sign(rs2); remainder sign = sign(rs1)), select low/high product half or quotient/remainder, ->DONE.
REQ-026 MULHSU SHALL treat rs1 signed, rs2 unsigned; MULH/MULHU result = product[2XLEN-1:XLEN]; MUL = product[XLEN-1:0].
REQ-027 Latency SHALL be: iterative ops out_valid high XLEN+2 edges after acceptance edge; fast-path ops (REQ-020..022) 1 edge after.
REQ-028 In DONE out_valid=1; result, out_tag, out_illegal SHALL be stable until the out_ready=1 edge, then ->IDLE.
REQ-029 No new request SHALL be accepted in the DONE->IDLE edge (back-to-back throughput one op per >=2 cycles fast path).
REQ-030 flush=1 SHALL force ->IDLE at next edge from any state, dropping any result, and SHALL block acceptance in that cycle; flush wins over out_ready.
REQ-031 Outside DONE, out_valid=0 and result/out_tag/out_illegal SHALL hold last values (no X).

Reset
REQ-032 rst_n=0 SHALL immediately force state=IDLE, counter=0, result=0, out_tag=0, out_illegal=0, out_valid=0; in_ready=1 after reset release (first rising edge with rst_n=1 may accept).
REQ-033 Reset mid-CALC SHALL abandon the operation with no out_valid pulse.

Verification (XLEN=32)
REQ-034 MUL rs1=7, rs2=0xFFFFFFFD -> out_valid at edge 34 after accept, result=0xFFFFFFEB, tag echoed.
REQ-035 MULH rs1=0x80000000, rs2=0x80000000 -> result=0x40000000; MULHU same operands -> 0x40000000; MULHSU rs1=0xFFFFFFFF, rs2=0xFFFFFFFF -> 0xFFFFFFFF.
REQ-036 DIV rs1=-7, rs2=2 -> 0xFFFFFFFD; REM -> 0xFFFFFFFF; DIVU 0 divisor -> 0xFFFFFFFF one edge after accept; DIV 0x80000000/-1 -> 0x80000000.
REQ-037 Instruction 0x00B50533 (ADD) -> out_illegal=1, result=0, one edge after accept.
REQ-038 out_ready held low 10 cycles in DONE -> result stable, in_ready=0; flush asserted at CALC cycle 5 -> IDLE next edge, no out_valid.
REQ-039 rst_n pulsed low mid-CALC -> all outputs zero asynchronously, in_ready=1 after release.

Source files
------------

// File: rtl/riscv_mdu_seq.sv
// Sequential RV32 M-extension unit: radix-2 shift-add multiply and restoring divide.
// Divide-by-zero, signed overflow and illegal instructions complete through a one-cycle fast path.
module riscv_mdu_seq #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned TAGW = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instruction,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic [TAGW-1:0] in_tag,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic [TAGW-1:0] out_tag,
    output logic            out_illegal
);

    localparam int unsigned CW = $clog2(XLEN) + 1;
    localparam logic [XLEN-1:0] MinNeg = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [2:0]        op_q, op_d;
    logic [XLEN-1:0]   a_q, a_d;
    logic [2*XLEN-1:0] p_q, p_d;
    logic              neg_q, neg_d;
    logic [TAGW-1:0]   tag_q, tag_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic [TAGW-1:0]   out_tag_q, out_tag_d;
    logic              illegal_q, illegal_d;

    logic              accept, legal, is_div, div_zero, div_ovf, s1, s2;
    logic [2:0]        f3;
    logic [XLEN-1:0]   mag1, mag2;
    logic [XLEN:0]     mul_sum, rem_sh, diff;
    logic              qbit;
    logic [2*XLEN-1:0] mul_next, div_next, prod_n;
    logic [XLEN-1:0]   dsel;
    logic              unused_instr;

    assign unused_instr = ^{instruction[24:15], instruction[11:7]};

    assign in_ready    = (state_q == StIdle);
    assign out_valid   = (state_q == StDone);
    assign result      = result_q;
    assign out_tag     = out_tag_q;
    assign out_illegal = illegal_q;

    assign accept   = in_valid & in_ready & ~flush;
    assign legal    = (instruction[6:0] == 7'b0110011) && (instruction[31:25] == 7'b0000001);
    assign f3       = instruction[14:12];
    assign is_div   = f3[2];
    assign div_zero = (rs2 == '0);
    assign div_ovf  = ~f3[0] && (rs1 == MinNeg) && (rs2 == '1);

    // Operand signedness: MULH both, MULHSU rs1 only, DIV/REM both; MUL low half is sign-agnostic.
    assign s1   = rs1[XLEN-1] & (is_div ? ~f3[0] : (f3 == 3'b001 || f3 == 3'b010));
    assign s2   = rs2[XLEN-1] & (is_div ? ~f3[0] : (f3 == 3'b001));
    assign mag1 = s1 ? (~rs1 + 1'b1) : rs1;
    assign mag2 = s2 ? (~rs2 + 1'b1) : rs2;

    assign mul_sum  = {1'b0, p_q[2*XLEN-1:XLEN]} + (p_q[0] ? {1'b0, a_q} : '0);
    assign mul_next = {mul_sum, p_q[XLEN-1:1]};

    // Restoring step: high half is the partial remainder, low half shifts dividend out / quotient in.
    assign rem_sh   = {p_q[2*XLEN-1:XLEN], p_q[XLEN-1]};
    assign diff     = rem_sh - {1'b0, a_q};
    assign qbit     = ~diff[XLEN];
    assign div_next = {(qbit ? diff[XLEN-1:0] : rem_sh[XLEN-1:0]), p_q[XLEN-2:0], qbit};

    assign prod_n = neg_q ? (~p_q + 1'b1) : p_q;
    assign dsel   = op_q[1] ? p_q[2*XLEN-1:XLEN] : p_q[XLEN-1:0];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        a_d       = a_q;
        p_d       = p_q;
        neg_d     = neg_q;
        tag_d     = tag_q;
        result_d  = result_q;
        out_tag_d = out_tag_q;
        illegal_d = illegal_q;
        if (flush) begin
            state_d = StIdle;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        tag_d = in_tag;
                        op_d  = f3;
                        if (!legal) begin
                            state_d   = StDone;
                            result_d  = '0;
                            out_tag_d = in_tag;
                            illegal_d = 1'b1;
                        end else if (is_div && (div_zero || div_ovf)) begin
                            state_d   = StDone;
                            out_tag_d = in_tag;
                            illegal_d = 1'b0;
                            if (div_zero) result_d = f3[1] ? rs1 : '1;
                            else          result_d = f3[1] ? '0 : rs1;
                        end else begin
                            state_d = StCalc;
                            cnt_d   = '0;
                            a_d     = is_div ? mag2 : mag1;
                            p_d     = {{XLEN{1'b0}}, (is_div ? mag1 : mag2)};
                            neg_d   = (is_div && f3[1]) ? s1 : (s1 ^ s2);
                        end
                    end
                end
                StCalc: begin
                    p_d = op_q[2] ? div_next : mul_next;
                    if (cnt_q == CW'(XLEN - 1)) begin
                        state_d = StFix;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                StFix: begin
                    state_d   = StDone;
                    out_tag_d = tag_q;
                    illegal_d = 1'b0;
                    if (op_q[2])              result_d = neg_q ? (~dsel + 1'b1) : dsel;
                    else if (op_q[1:0] == '0) result_d = prod_n[XLEN-1:0];
                    else                      result_d = prod_n[2*XLEN-1:XLEN];
                end
                StDone: begin
                    if (out_ready) state_d = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            op_q      <= '0;
            a_q       <= '0;
            p_q       <= '0;
            neg_q     <= 1'b0;
            tag_q     <= '0;
            result_q  <= '0;
            out_tag_q <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            a_q       <= a_d;
            p_q       <= p_d;
            neg_q     <= neg_d;
            tag_q     <= tag_d;
            result_q  <= result_d;
            out_tag_q <= out_tag_d;
            illegal_q <= illegal_d;
        end
    end

endmodule

// File: tb/tb_riscv_mdu_seq.sv
// Scoreboard bench for riscv_mdu_seq: stimulus pushes expectations, a negedge monitor pops them.
module tb_riscv_mdu_seq;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  tag;
        logic        ill;
        int          lat;
        int          acc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] instruction = '0;
    logic [31:0] rs1 = '0;
    logic [31:0] rs2 = '0;
    logic [4:0]  in_tag = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] result;
    logic [4:0]  out_tag;
    logic        out_illegal;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   rdy_mode = 1;
    exp_t sbq[$];

    riscv_mdu_seq #(.XLEN(32), .TAGW(5)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .instruction(instruction), .rs1(rs1), .rs2(rs2), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .result(result), .out_tag(out_tag),
        .out_illegal(out_illegal)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial forever begin
        @(posedge clk);
        #1;
        if (rdy_mode == 0)      out_ready = 1'b0;
        else if (rdy_mode == 1) out_ready = 1'b1;
        else                    out_ready = 1'($urandom_range(0, 1));
    end

    function automatic logic [31:0] mk(input logic [2:0] f3);
        return {7'b0000001, 5'd2, 5'd1, f3, 5'd3, 7'b0110011};
    endfunction

    // Reference model: RISC-V M-extension semantics from plain 64-bit arithmetic.
    function automatic exp_t model(input logic [31:0] ins, input logic [31:0] a,
                                   input logic [31:0] b, input logic [4:0] tag);
        exp_t        e;
        logic [63:0] p;
        longint      sa, sb, ub;
        e.tag = tag; e.ill = 1'b0; e.lat = 34; e.acc = 0; e.res = '0;
        if (ins[6:0] != 7'h33 || ins[31:25] != 7'h01) begin
            e.ill = 1'b1; e.lat = 1;
            return e;
        end
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ub = longint'({32'b0, b});
        case (ins[14:12])
            3'd0: begin p = 64'(sa * sb); e.res = p[31:0]; end
            3'd1: begin p = 64'(sa * sb); e.res = p[63:32]; end
            3'd2: begin p = 64'(sa * ub); e.res = p[63:32]; end
            3'd3: begin p = {32'b0, a} * {32'b0, b}; e.res = p[63:32]; end
            3'd4: begin
                if (b == 0) begin e.res = 32'hFFFF_FFFF; e.lat = 1; end
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin e.res = a; e.lat = 1; end
                else e.res = 32'(sa / sb);
            end
            3'd5: begin
                if (b == 0) begin e.res = 32'hFFFF_FFFF; e.lat = 1; end
                else e.res = a / b;
            end
            3'd6: begin
                if (b == 0) begin e.res = a; e.lat = 1; end
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin e.res = 0; e.lat = 1; end
                else e.res = 32'(sa % sb);
            end
            default: begin
                if (b == 0) begin e.res = a; e.lat = 1; end
                else e.res = a % b;
            end
        endcase
        return e;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
        end
    endtask

    // use_lit: push the given literal expectation; otherwise push the model's; push: 0 drops it.
    task automatic issue(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] tag, input bit push, input bit use_lit,
                         input logic [31:0] lres, input logic lill, input int llat);
        exp_t e;
        int   n;
        @(negedge clk);
        instruction = ins; rs1 = a; rs2 = b; in_tag = tag; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 200) begin @(negedge clk); n++; end
        if (!in_ready) begin
            checks++; errors++;
            $display("FAIL accept_timeout actual=in_ready0 required=in_ready1");
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (push) begin
            e = model(ins, a, b, tag);
            if (use_lit) begin e.res = lres; e.ill = lill; e.lat = llat; end
            e.acc = cyc;
            sbq.push_back(e);
        end
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((sbq.size() != 0 || !in_ready) && n < 2000) begin @(negedge clk); n++; end
        chk("drain", {31'b0, (sbq.size() == 0 && in_ready)}, 32'd1);
    endtask

    task automatic watch_quiet(input string name, input int cycles);
        bit seen_v = 1'b0;
        repeat (cycles) begin
            @(negedge clk);
            if (out_valid) seen_v = 1'b1;
        end
        chk(name, {31'b0, seen_v}, 32'd0);
    endtask

    initial begin : monitor
        bit          seen = 1'b0;
        exp_t        e;
        logic [31:0] h_res;
        logic [4:0]  h_tag;
        logic        h_ill;
        forever begin
            @(negedge clk);
            if (!rst_n || !out_valid) begin
                seen = 1'b0;
            end else begin
                if (!seen) begin
                    if (sbq.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_valid actual=result 0x%08h required=no_output",
                                 result);
                    end else begin
                        e = sbq.pop_front();
                        chk("result", result, e.res);
                        chk("tag", {27'b0, out_tag}, {27'b0, e.tag});
                        chk("illegal", {31'b0, out_illegal}, {31'b0, e.ill});
                        chk("latency", 32'(cyc - e.acc + 1), 32'(e.lat));
                    end
                    seen = 1'b1;
                    h_res = result; h_tag = out_tag; h_ill = out_illegal;
                end else begin
                    chk("hold", {result, out_tag, out_illegal} == {h_res, h_tag, h_ill} ? 32'd1 : 32'd0,
                        32'd1);
                end
                if (out_ready && !flush) seen = 1'b0;
            end
        end
    end

    initial begin
        logic [31:0] ins;
        #1;
        chk("rst_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_tag", {27'b0, out_tag}, 32'd0);
        chk("rst_illegal", {31'b0, out_illegal}, 32'd0);
        chk("rst_ready", {31'b0, in_ready}, 32'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        issue(mk(3'd0), 32'd7, 32'hFFFF_FFFD, 5'd3, 1, 1, 32'hFFFF_FFEB, 1'b0, 34);
        issue(mk(3'd1), 32'h8000_0000, 32'h8000_0000, 5'd4, 1, 1, 32'h4000_0000, 1'b0, 34);
        issue(mk(3'd3), 32'h8000_0000, 32'h8000_0000, 5'd5, 1, 1, 32'h4000_0000, 1'b0, 34);
        issue(mk(3'd2), 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6, 1, 1, 32'hFFFF_FFFF, 1'b0, 34);
        issue(mk(3'd4), 32'hFFFF_FFF9, 32'd2, 5'd7, 1, 1, 32'hFFFF_FFFD, 1'b0, 34);
        issue(mk(3'd6), 32'hFFFF_FFF9, 32'd2, 5'd8, 1, 1, 32'hFFFF_FFFF, 1'b0, 34);
        issue(mk(3'd5), 32'd1234, 32'd0, 5'd9, 1, 1, 32'hFFFF_FFFF, 1'b0, 1);
        issue(mk(3'd4), 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 1, 1, 32'h8000_0000, 1'b0, 1);
        issue(32'h00B5_0533, 32'd5, 32'd6, 5'd11, 1, 1, 32'd0, 1'b1, 1);
        wait_drain();

        rdy_mode = 2;
        for (int i = 0; i < 50; i++) begin
            ins = mk(3'($urandom_range(0, 7)));
            ins[11:7] = 5'($urandom);
            if ($urandom_range(0, 9) == 0) ins[31:25] = 7'h00;
            if ($urandom_range(0, 19) == 0) ins[6:0] = 7'h13;
            issue(ins, pick(), pick(), 5'($urandom), 1, 0, 32'd0, 1'b0, 0);
        end
        rdy_mode = 1;
        wait_drain();

        rdy_mode = 0;
        issue(mk(3'd0), 32'd7, 32'd3, 5'd9, 1, 0, 32'd0, 1'b0, 0);
        begin
            int n = 0;
            while (!out_valid && n < 100) begin @(negedge clk); n++; end
        end
        chk("stall_reach", {31'b0, out_valid}, 32'd1);
        repeat (10) begin
            @(negedge clk);
            chk("stall_in_ready", {31'b0, in_ready}, 32'd0);
            chk("stall_valid", {31'b0, out_valid}, 32'd1);
        end
        rdy_mode = 1;
        wait_drain();

        issue(mk(3'd1), 32'h1234_5678, 32'h9ABC_DEF0, 5'd20, 0, 0, 32'd0, 1'b0, 0);
        repeat (5) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        chk("flush_idle", {31'b0, in_ready}, 32'd1);
        chk("flush_result_kept", result, 32'd21);
        watch_quiet("flush_no_valid", 40);

        issue(mk(3'd5), 32'hDEAD_BEEF, 32'd3, 5'd21, 0, 0, 32'd0, 1'b0, 0);
        repeat (10) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_result", result, 32'd0);
        chk("arst_tag", {27'b0, out_tag}, 32'd0);
        chk("arst_valid", {31'b0, out_valid}, 32'd0);
        chk("arst_ready", {31'b0, in_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("arst_release_ready", {31'b0, in_ready}, 32'd1);
        watch_quiet("arst_no_valid", 40);

        issue(mk(3'd7), 32'd100, 32'd7, 5'd22, 1, 0, 32'd0, 1'b0, 0);
        wait_drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
